pulse_burst_monitor: RTL and testbench

- Downstream consumer of the nested row/column counter controller. Samples its pulse output (`out`) and completion flag (`done`), and measures each burst: cycles per row, row count and total high cycles.
- On every completion it pushes one summary record into a small first-word-fall-through FIFO, read over a valid/ready handshake.
- Sits between the counter controller and the result/reporting logic.

---
 rtl/pulse_burst_monitor.sv | 169 ++++++++++++++++
 tb/tb_pulse_burst_monitor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_monitor.sv
// Measures row/column pulse bursts from the counter controller and queues one
// {err, rows, total} record per completion in a FWFT FIFO. Error checking: BURST_MON_ERRCHK_EN.
module pulse_burst_monitor #(
    parameter int CW          = 8,
    parameter int ROW_LEN_EXP = 9,
    parameter int ROWS_EXP    = 9,
    parameter int DEPTH       = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          pulse_in,
    input  logic          done_in,
    output logic          rec_valid,
    input  logic          rec_ready,
    output logic [CW+4:0] rec_data,
    output logic          fifo_full,
    output logic          overflow
);
    localparam int RW = CW + 5;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CMAX = '1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ROW_LEN_EXP < 0 ||
        ROW_LEN_EXP > (2 ** CW) - 1 || ROWS_EXP < 0 || ROWS_EXP > 15) begin : g_bad_params
        $error("pulse_burst_monitor: illegal parameter combination");
    end

    // Handshake: a record moves when rec_valid && rec_ready at a rising clk edge;
    // rec_data is held stable while rec_valid=1 and rec_ready=0.

    typedef enum logic [1:0] {IDLE, IN_ROW, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] run_len, run_n;
    logic [CW-1:0] total, total_n;
    logic [3:0]    rows, rows_n;
    logic          done_q;
    logic          done_rise;
    logic          row_close;
    logic          rec_err;
    logic          push;
    logic [RW-1:0] push_data;

    assign done_rise = done_in && !done_q;
    assign push      = enable && done_rise;

    always_comb begin
        state_n   = state;
        run_n     = run_len;
        total_n   = total;
        rows_n    = rows;
        row_close = 1'b0;
        if (pulse_in) begin
            state_n = IN_ROW;
            if (state != IN_ROW) begin
                run_n = CW'(1);
            end else if (run_len != CMAX) begin
                run_n = run_len + 1'b1;
            end
            if (total != CMAX) begin
                total_n = total + 1'b1;
            end
        end else if (state == IN_ROW) begin
            state_n   = GAP;
            row_close = 1'b1;
        end
        // A done arriving on a pulse cycle closes the row that pulse belongs to.
        if (done_rise && pulse_in) begin
            row_close = 1'b1;
        end
        if (row_close && rows != 4'hf) begin
            rows_n = rows + 1'b1;
        end
    end

`ifdef BURST_MON_ERRCHK_EN
    logic err_acc;
    logic err_cycle;

    always_comb begin
        err_cycle = 1'b0;
        if (row_close && run_n != CW'(ROW_LEN_EXP)) err_cycle = 1'b1;
        if (pulse_in && state == IN_ROW && run_len == CMAX) err_cycle = 1'b1;
        if (pulse_in && total == CMAX) err_cycle = 1'b1;
        if (row_close && rows == 4'hf) err_cycle = 1'b1;
    end

    assign rec_err = err_acc || err_cycle || (rows_n != 4'(ROWS_EXP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_acc <= 1'b0;
        end else if (enable) begin
            if (done_rise) err_acc <= 1'b0;
            else           err_acc <= err_acc || err_cycle;
        end
    end
`else
    assign rec_err = 1'b0;
`endif

    assign push_data = {rec_err, rows_n, total_n};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            run_len <= '0;
            total   <= '0;
            rows    <= '0;
            done_q  <= 1'b0;
        end else if (enable) begin
            done_q <= done_in;
            if (done_rise) begin
                state   <= IDLE;
                run_len <= '0;
                total   <= '0;
                rows    <= '0;
            end else begin
                state   <= state_n;
                run_len <= row_close ? '0 : run_n;
                total   <= total_n;
                rows    <= rows_n;
            end
        end
    end

    // Record FIFO: occupancy counter with one extra bit so DEPTH is representable.
    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_n;
    logic          pop, push_ok;

    assign pop     = rec_valid && rec_ready;
    assign push_ok = push && (!fifo_full || pop);

    always_comb begin
        count_n = count;
        case ({push_ok, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count     <= count_n;
            fifo_full <= (count_n == (AW + 1)'(DEPTH));
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    assign rec_valid = (count != '0);
    assign rec_data  = rec_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_pulse_burst_monitor.sv
// Directed bench for pulse_burst_monitor: bursts are driven as row/gap patterns and
// expected records are queued at stimulus time, then compared as the FIFO is drained.
module tb_pulse_burst_monitor;
    localparam int CW = 8;
    localparam int RW = CW + 5;
`ifdef BURST_MON_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          pulse_in = 1'b0;
    logic          done_in = 1'b0;
    logic          rec_ready = 1'b0;
    logic          rec_valid;
    logic [RW-1:0] rec_data;
    logic          fifo_full;
    logic          overflow;

    logic [RW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    pulse_burst_monitor #(.CW(CW), .ROW_LEN_EXP(9), .ROWS_EXP(9), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in), .done_in(done_in),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one sampled cycle; returns at the following falling edge.
    task automatic step(input logic p, input logic d);
        pulse_in = p;
        done_in  = d;
        @(negedge clk);
    endtask

    task automatic burst(input int nrows, input int len, input int odd_row, input int odd_len,
                         input bit coincident, input bit ready_at_done, input bit expect_push,
                         input bit chk_lat);
        int rl;
        int tot = 0;
        bit bad = 0;
        bit sat = 0;
        bit err;
        logic [3:0] rows_e;
        logic [CW-1:0] tot_e;
        for (int r = 0; r < nrows; r++) begin
            rl = (r == odd_row) ? odd_len : len;
            tot += rl;
            if (rl != 9) bad = 1;
            if (rl > 255) sat = 1;
            for (int c = 0; c < rl; c++) begin
                if (coincident && r == nrows - 1 && c == rl - 1) begin
                    if (chk_lat) check("pre_done_valid", 16'(rec_valid), 16'd0);
                    rec_ready = ready_at_done;
                    step(1'b1, 1'b1);
                    if (chk_lat) check("latency_valid", 16'(rec_valid), 16'd1);
                end else begin
                    step(1'b1, 1'b0);
                end
            end
            if (!coincident || r != nrows - 1) begin
                if (r == nrows - 1) begin
                    if (chk_lat) check("pre_done_valid", 16'(rec_valid), 16'd0);
                    rec_ready = ready_at_done;
                    step(1'b0, 1'b1);
                    if (chk_lat) check("latency_valid", 16'(rec_valid), 16'd1);
                end else begin
                    step(1'b0, 1'b0);
                end
            end
        end
        if (nrows == 0) begin
            rec_ready = ready_at_done;
            step(1'b0, 1'b1);
        end
        rec_ready = 1'b0;
        if (coincident) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b1);
        end
        step(1'b0, 1'b0);
        if (tot > 255) begin
            tot = 255;
            sat = 1;
        end
        err    = ERRCHK && (bad || sat || nrows != 9);
        rows_e = 4'(nrows);
        tot_e  = CW'(tot);
        if (expect_push) exp_q.push_back({err, rows_e, tot_e});
    endtask

    task automatic pop_one(input string tag);
        logic [RW-1:0] exp;
        int waited = 0;
        while (!rec_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, 16'(rec_valid), 16'd1);
        if (!rec_valid) return;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 16'(rec_valid), 16'd0);
            return;
        end
        exp = exp_q.pop_front();
        check(tag, 16'(rec_data), 16'(exp));
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_valid", 16'(rec_valid), 16'd0);
        check("rst_full", 16'(fifo_full), 16'd0);
        check("rst_ovf", 16'(overflow), 16'd0);
        check("rst_data", 16'(rec_data), 16'd0);
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Reset in the middle of a row discards the partial counts
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        pulse_in = 1'b0;
        #2 reset = 1'b1;
        #2 check("midrow_rst_valid", 16'(rec_valid), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0);
        check("after_rst_valid", 16'(rec_valid), 16'd0);

        // Nominal 9x9 burst, done on the final low cycle
        burst(9, 9, -1, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        pop_one("nominal");
        check("nominal_empty", 16'(rec_valid), 16'd0);

        // Short fourth row
        burst(9, 9, 3, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        pop_one("short_row");

        // done coincident with the last pulse, held for three cycles
        burst(9, 9, -1, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        pop_one("coincident");
        repeat (2) @(negedge clk);
        check("single_push", 16'(rec_valid), 16'd0);

        // Empty burst and a saturating single row
        burst(0, 0, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        pop_one("empty_burst");
        burst(1, 300, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        pop_one("saturate");

        // Overflow: five bursts with the consumer stalled
        for (int b = 1; b <= 4; b++) burst(b, 2, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fill_full", 16'(fifo_full), 16'd1);
        check("fill_ovf", 16'(overflow), 16'd0);
        burst(5, 2, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop_full", 16'(fifo_full), 16'd1);
        check("drop_ovf", 16'(overflow), 16'd1);
        for (int b = 0; b < 4; b++) pop_one("drain_order");
        check("drain_ovf_sticky", 16'(overflow), 16'd1);
        check("drain_full", 16'(fifo_full), 16'd0);
        check("drain_empty", 16'(rec_valid), 16'd0);

        // Reset clears overflow; then push and pop together while full
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst2_ovf", 16'(overflow), 16'd0);
        for (int b = 1; b <= 4; b++) burst(b, 3, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pp_pre_full", 16'(fifo_full), 16'd1);
        check("pp_head", 16'(rec_data), 16'(exp_q[0]));
        void'(exp_q.pop_front());
        burst(6, 3, -1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("pp_full", 16'(fifo_full), 16'd1);
        check("pp_ovf", 16'(overflow), 16'd0);
        for (int b = 0; b < 4; b++) pop_one("pp_order");
        check("pp_empty", 16'(rec_valid), 16'd0);

        // enable low: toggling inputs must not disturb a burst in progress
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step(1'(i % 2), 1'(i % 3 == 0));
        check("disabled_no_rec", 16'(rec_valid), 16'd0);
        step(1'b0, 1'b0);
        enable = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        exp_q.push_back({ERRCHK, 4'd1, 8'd5});
        pop_one("enable_hold");
        check("final_queue", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
